// File: rtl/mul_seq_pkg.sv
// Shared types and sizing for the shift-and-add multiply sequencer.
// Keep MUL_WIDTH in step with the 32-bit Adder it drives.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_CNT_W = 5;

endpackage

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle MUL sequencer: feeds an external adder one partial product
// per cycle and keeps the low word of src1*src2.
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] add_a_o,
  output logic [WIDTH-1:0] add_b_o,
  input  logic [WIDTH-1:0] add_sum_i
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_iter;

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1))
                  || ((mplier_q >> 1) == '0);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    add_a_o  = '0;
    add_b_o  = '0;
    unique case (state_q)
      IDLE: begin
        if (!abort_i && start_i) begin
          mcand_d  = src1_i;
          mplier_d = src2_i;
          acc_d    = '0;
          cnt_d    = '0;
          if (src2_i != '0) begin
            state_d = RUN;
          end else begin
            state_d  = DONE;
            result_d = '0;
          end
        end
      end
      RUN: begin
        add_a_o = acc_q;
        add_b_o = mplier_q[0] ? mcand_q : '0;
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          acc_d    = add_sum_i;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (last_iter) begin
            state_d  = DONE;
            result_d = add_sum_i;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ready_o  = (state_q == IDLE);
  // an abort landing on the DONE cycle swallows the pulse
  assign done_o   = (state_q == DONE) && !abort_i;
  assign result_o = result_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl; a behavioural 32-bit adder closes
// the add_a/add_b -> add_sum loop.
module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;

  int passed = 0;
  int total  = 0;

  assign add_sum = add_a + add_b;

  mul_seq_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .abort_i  (abort),
    .src1_i   (src1),
    .src2_i   (src2),
    .ready_o  (ready),
    .done_o   (done),
    .result_o (result),
    .add_a_o  (add_a),
    .add_b_o  (add_b),
    .add_sum_i(add_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Issue start at the next rising edge (E0); leaves the bench just
  // after E0 so the following negedge is cycle 1.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    src1  = a;
    src2  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    src1  = 32'hDEAD_BEEF;
    src2  = 32'hCAFE_F00D;
  endtask

  // Wait (bounded) for done_o, sampling on falling edges.
  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      cyc = c;
      if (done) break;
    end
    if (!done) cyc = 99;
  endtask

  task automatic run(input string tag,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] exp_res,
                     input int k);
    int cyc;
    issue(a, b);
    wait_done(cyc);
    check({tag, "_done_cycle"}, 32'(cyc), 32'(k + 1));
    check({tag, "_result"}, result, exp_res);
  endtask

  initial begin
    int cyc;
    int seen;
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    src1  = '0;
    src2  = '0;
    #2;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_add_a", add_a, 32'd0);
    check("rst_add_b", add_b, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // 7*6: three RUN cycles, with ready/adder probes along the way
    issue(32'd7, 32'd6);
    @(negedge clk);
    check("m76_c1_ready", 32'(ready), 32'd0);
    check("m76_c1_add_b", add_b, 32'd0);
    @(negedge clk);
    check("m76_c2_add_a", add_a, 32'd0);
    check("m76_c2_add_b", add_b, 32'd14);
    @(negedge clk);
    check("m76_c3_add_a", add_a, 32'd14);
    check("m76_c3_add_b", add_b, 32'd28);
    check("m76_c3_done", 32'(done), 32'd0);
    @(negedge clk);
    check("m76_c4_done", 32'(done), 32'd1);
    check("m76_c4_ready", 32'(ready), 32'd0);
    check("m76_result", result, 32'd42);
    @(negedge clk);
    check("m76_c5_ready", 32'(ready), 32'd1);
    check("m76_c5_done", 32'(done), 32'd0);

    // abort in the second RUN cycle of 7*0xFF
    issue(32'd7, 32'hFF);
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_ready", 32'(ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    check("abort_result_kept", result, 32'd42);

    // abort together with start in IDLE drops the start
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    src1  = 32'd5;
    src2  = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_ready", 32'(ready), 32'd1);
    @(negedge clk);
    check("abort_start_done", 32'(done), 32'd0);
    check("abort_start_result", result, 32'd42);

    run("zero", 32'h1234_5678, 32'd0, 32'd0, 0);
    run("ffsq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32);
    run("wrap", 32'h8000_0000, 32'd2, 32'd0, 2);
    run("neg", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 3);

    // second start during RUN is ignored
    issue(32'd7, 32'd6);
    @(negedge clk);
    start = 1'b1;
    src1  = 32'd5;
    src2  = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc);
    check("busy_done_cycle", 32'(cyc + 1), 32'd4);
    check("busy_result", result, 32'd42);
    @(negedge clk);
    @(negedge clk);
    check("busy_no_restart", 32'(ready), 32'd1);

    // asynchronous reset between edges mid-RUN
    issue(32'hFF, 32'hFF);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_ready", 32'(ready), 32'd1);
    check("arst_done", 32'(done), 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run("m33", 32'd3, 32'd3, 32'd9, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle shift-and-add sequencer that computes the low WIDTH bits of src1*src2 (MIPS MUL semantics; low word identical for signed and unsigned).
- Does not contain its own adder. It drives the operand inputs of an external 32-bit Adder instance and registers that adder's sum each cycle.
- Sits beside the ALU. The CPU control stalls on ready_o and reads result_o when done_o pulses.

Parameters:
- WIDTH, 32, operand/result width; must match the Adder instance.
- CNT_W, 5, iteration counter width; equals log2(WIDTH).

Ports:
- clk_i  in  1  system clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- start_i  in  1  request; sampled only when ready_o=1.
- abort_i  in  1  synchronous flush; returns to IDLE with no done_o.
- src1_i  in  WIDTH  multiplicand; captured with start.
- src2_i  in  WIDTH  multiplier; captured with start.
- ready_o  out  1  high only in IDLE.
- done_o  out  1  one-cycle pulse, high in DONE.
- result_o  out  WIDTH  product low word; registered.
- add_a_o  out  WIDTH  drives Adder src1_i.
- add_b_o  out  WIDTH  drives Adder src2_i.
- add_sum_i  in  WIDTH  from Adder sum_o; combinational, same cycle.

Behaviour:
- Reset (rst_i=0, any state, asynchronous):
  - state=IDLE; mcand, mplier, acc, cnt, result_o all 0.
  - ready_o=1, done_o=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready_o=1; add_a_o=0, add_b_o=0.
  - On start_i=1: mcand<=src1_i, mplier<=src2_i, acc<=0, cnt<=0.
  - Next state is RUN if src2_i!=0, otherwise DONE (zero multiplier skips iteration).
- RUN (one iteration per cycle):
  - add_a_o=acc; add_b_o = mplier[0] ? mcand : 0.
  - Registers update: acc<=add_sum_i; mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
  - Exit to DONE when cnt==WIDTH-1 or (mplier>>1)==0 (early termination).
  - Number of RUN cycles = index of highest set bit of src2 + 1, between 1 and WIDTH.
  - Arithmetic is modulo 2^WIDTH; carries past bit WIDTH-1 are discarded, as in the Adder itself.
- DONE:
  - done_o=1 for exactly one cycle; result_o is loaded with acc on entry to DONE.
  - Next state is IDLE unconditionally. start_i in DONE is ignored.
- result_o holds its value until the next completed operation; it is not cleared by start or abort.
- Latency: start accepted at edge E0 → done_o high in cycle k+1 after E0, where k = RUN cycles (k=0 for a zero multiplier).
- start_i while ready_o=0 is ignored; there is no queuing.
- abort_i=1 in RUN or DONE → IDLE next edge; acc and result_o are unchanged and done_o does not pulse (suppressed in the abort cycle).
- abort_i together with start_i in IDLE: abort wins and start is dropped.
- Outputs add_a_o/add_b_o are combinational from registers only; there is no path from start_i or src*_i.
- Reset mid-RUN: immediate return to IDLE, no done_o; the partial product is discarded.

Decomposition:
- Package mul_seq_pkg holds:
  - enum state_t {IDLE, RUN, DONE} (2-bit);
  - localparam MUL_WIDTH=32;
  - localparam MUL_CNT_W=5.
- Natural sub-module: mul_unit, a thin top that instantiates mul_seq_ctrl plus one Adder and wires add_a_o/add_b_o/add_sum_i. Benches test mul_unit.
- The controller stays adder-agnostic so a shared-adder arbiter can be inserted later.

Test Plan:
- 7 * 6:
  - start at E0 → 3 RUN cycles; done_o high in cycle 4; result_o=42.
  - ready_o low cycles 1-4, high in cycle 5.
- 0x12345678 * 0 → no RUN; done_o in cycle 1; result_o=0.
- 0xFFFFFFFF * 0xFFFFFFFF:
  - 32 RUN cycles; result_o=0x00000001; done_o in cycle 33.
- 0x80000000 * 2 → result_o=0 (wrap). Also (-3)*5 as 0xFFFFFFFD*5 → 0xFFFFFFF1.
- Busy and abort:
  - start_i pulsed again during RUN with new operands → ignored; first result returned.
  - abort_i in the 2nd RUN cycle of 7*0xFF → IDLE, no done_o, result_o keeps its previous value (42).
- Reset:
  - rst_i=0 asynchronously mid-RUN (between edges) → ready_o=1, done_o=0, result_o=0 immediately.
  - After release, 3*3 → 9.
